// File: rtl/irq_injector.sv
// irq_injector: synchronises and qualifies N event sources, latches them as pending,
// and presents one instruction at a time to the CPU via a round-robin valid/ack arbiter.
module irq_injector #(
    parameter int unsigned        NUM_SRC     = 4,
    parameter int unsigned        INSTR_W     = 32,
    parameter int unsigned        SYNC_STAGES = 2,
    parameter logic [NUM_SRC-1:0] EDGE_MASK   = '1,
    localparam int unsigned       SRC_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_SRC-1:0]         src_in,
    input  logic [NUM_SRC-1:0]         src_enable,
    input  logic [NUM_SRC*INSTR_W-1:0] src_instr,
    output logic                       irq_valid,
    output logic [INSTR_W-1:0]         irq_instr,
    output logic [SRC_W-1:0]           irq_src,
    input  logic                       irq_ack,
    output logic [NUM_SRC-1:0]         pending,
    output logic [NUM_SRC-1:0]         overrun
);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t                   state;
    logic [SRC_W-1:0]         last_grant;
    logic [SYNC_STAGES-1:0]   sync_chain [NUM_SRC];
    logic [NUM_SRC-1:0]       sync;
    logic [NUM_SRC-1:0]       prev;
    logic [NUM_SRC-1:0]       in_service;
    logic [NUM_SRC-1:0]       evt;
    logic [NUM_SRC-1:0]       grant_onehot;
    logic [NUM_SRC-1:0]       pending_d;
    logic [NUM_SRC-1:0]       overrun_d;
    logic [INSTR_W-1:0]       instr_tab [NUM_SRC];
    logic                     grant_valid;
    logic [SRC_W-1:0]         grant_idx;
    logic [SRC_W-1:0]         cand;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        always_ff @(posedge clk) begin
            if (reset) begin
                sync_chain[i] <= '0;
            end else begin
                sync_chain[i] <= {sync_chain[i][SYNC_STAGES-2:0], src_in[i]};
            end
        end

        assign sync[i]      = sync_chain[i][SYNC_STAGES-1];
        assign instr_tab[i] = src_instr[i*INSTR_W +: INSTR_W];

        // A source being acked this cycle is already leaving service, so a held level re-pends at once
        assign in_service[i]   = (state == PRESENT) && (irq_src == SRC_W'(i)) && !irq_ack;
        assign evt[i]          = EDGE_MASK[i] ? (sync[i] & ~prev[i])
                                              : (sync[i] & ~pending[i] & ~in_service[i]);
        assign grant_onehot[i] = (state == IDLE) && grant_valid && (grant_idx == SRC_W'(i));

        assign pending_d[i] = !src_enable[i]           ? 1'b0 :
                              (evt[i] && !pending[i])  ? 1'b1 :
                              grant_onehot[i]          ? 1'b0 : pending[i];
        assign overrun_d[i] = overrun[i] | (EDGE_MASK[i] & src_enable[i] & evt[i] & pending[i]);
    end

    // Round-robin search starting just after the last granted source
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned off = 1; off <= NUM_SRC; off++) begin
            cand = SRC_W'((32'(last_grant) + off) % NUM_SRC);
            if (!grant_valid && pending[cand] && src_enable[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            irq_valid  <= 1'b0;
            irq_instr  <= '0;
            irq_src    <= '0;
            last_grant <= SRC_W'(NUM_SRC - 1);
            pending    <= '0;
            overrun    <= '0;
            prev       <= '0;
        end else begin
            pending <= pending_d;
            overrun <= overrun_d;
            prev    <= sync;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        irq_instr  <= instr_tab[grant_idx];
                        irq_src    <= grant_idx;
                        last_grant <= grant_idx;
                        irq_valid  <= 1'b1;
                        state      <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (irq_ack) begin
                        irq_valid <= 1'b0;
                        irq_instr <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
